// File: rtl/hid_pkg.sv
// Shared definitions for the HID MCU endpoint: command codes, status ID
// bytes and the quadrature gray-code step helpers.
package hid_pkg;

    typedef enum logic [7:0] {
        CMD_STATUS = 8'd0,
        CMD_KEY    = 8'd1,
        CMD_MOUSE  = 8'd2,
        CMD_JOY    = 8'd3,
        CMD_RATE   = 8'd4
    } cmd_e;

    localparam logic [7:0] STATUS_ID0 = 8'h5c;
    localparam logic [7:0] STATUS_ID1 = 8'h42;

    // Forward quadrature sequence 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] gray_fwd(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Reverse quadrature sequence 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] gray_rev(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hid_quad_axis.sv
// One mouse axis: saturating signed motion accumulator that drains one
// count per divider tick and emits the matching quadrature gray pair.
module hid_quad_axis
    import hid_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       add_en,
    input  logic [7:0] delta,
    input  logic       tick,
    output logic [1:0] q
);

    // Two guard bits hold acc + delta + step without overflow before saturation
    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] SUM_MAX = $signed({3'b000, {(CNT_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SUM_MIN = $signed({3'b111, {(CNT_W-1){1'b0}}});

    logic signed [CNT_W-1:0] acc_q, acc_d;
    logic [1:0]              q_q, q_d;
    logic                    acc_pos, acc_neg;
    logic signed [SUM_W-1:0] acc_ext, delta_ext, step_ext, sum;

    function automatic logic signed [CNT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] r;
        if (v > SUM_MAX)      r = SUM_MAX;
        else if (v < SUM_MIN) r = SUM_MIN;
        else                  r = v;
        return $signed(r[CNT_W-1:0]);
    endfunction

    // Step direction comes from the pre-add value, so a coincident add and
    // tick merge into one update: acc + delta - sign(acc).
    always_comb begin
        acc_neg   = acc_q[CNT_W-1];
        acc_pos   = !acc_neg && (acc_q != '0);
        acc_ext   = {{2{acc_q[CNT_W-1]}}, acc_q};
        delta_ext = add_en ? {{(SUM_W-8){delta[7]}}, delta} : '0;
        step_ext  = '0;
        q_d       = q_q;
        if (tick && acc_pos) begin
            step_ext = '1;
            q_d      = gray_fwd(q_q);
        end else if (tick && acc_neg) begin
            step_ext = {{(SUM_W-1){1'b0}}, 1'b1};
            q_d      = gray_rev(q_q);
        end
        sum   = acc_ext + delta_ext + step_ext;
        acc_d = sat(sum);
    end

    // Accumulator and gray output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            q_q   <= 2'b00;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hid_mcu_if.sv
// HID endpoint on the MCU byte link: frame parser feeding keyboard matrix,
// joystick ports, mouse buttons/axes and the mouse step-rate divider.
module hid_mcu_if
    import hid_pkg::*;
#(
    parameter int KBD_ROWS  = 15,
    parameter int JOY_COUNT = 2,
    parameter int CNT_W     = 10,
    parameter int DIV_W     = 14,
    parameter int DIV_RESET = 16383
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    data_in_strobe,
    input  logic                    data_in_start,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic [KBD_ROWS*8-1:0]   keyboard,
    output logic [JOY_COUNT*8-1:0]  joystick,
    output logic [2:0]              mouse_btn,
    output logic [1:0]              mouse_x,
    output logic [1:0]              mouse_y,
    output logic                    kbd_event
);

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_RESET[DIV_W-1:0];
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]              rst_sync_q, rst_sync_d;
    logic                    rst_n_int;

    logic [7:0]              cmd_q, cmd_d;
    logic [3:0]              idx_q, idx_d;
    logic [7:0]              dout_q, dout_d;
    logic [KBD_ROWS*8-1:0]   kbd_q, kbd_d;
    logic [JOY_COUNT*8-1:0]  joy_q, joy_d;
    logic [7:0]              dev_q, dev_d;
    logic [2:0]              btn_q, btn_d;
    logic                    kbd_event_q, kbd_event_d;
    logic [7:0]              rate_lo_q, rate_lo_d;
    logic [DIV_W-1:0]        reload_q, reload_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [DIV_W-1:0]        rate_full;
    logic                    tick;
    logic                    add_x, add_y;

    // Reset asserts immediately, releases two clocks after reset_n rises
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Reset synchroniser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    // Frame parser: start byte loads the command, later bytes act on it by index
    always_comb begin
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        dout_d      = dout_q;
        kbd_d       = kbd_q;
        joy_d       = joy_q;
        dev_d       = dev_q;
        btn_d       = btn_q;
        rate_lo_d   = rate_lo_q;
        reload_d    = reload_q;
        kbd_event_d = 1'b0;
        add_x       = 1'b0;
        add_y       = 1'b0;
        rate_full   = '0;
        if (data_in_strobe && data_in_start) begin
            cmd_d = data_in;
            idx_d = 4'd1;
        end else if (data_in_strobe && (idx_q != 4'd0)) begin
            idx_d = (idx_q == 4'd15) ? idx_q : idx_q + 4'd1;
            case (cmd_q)
                CMD_STATUS: begin
                    case (idx_q)
                        4'd1:    dout_d = STATUS_ID0;
                        4'd2:    dout_d = STATUS_ID1;
                        4'd3:    dout_d = 8'(JOY_COUNT);
                        4'd4:    dout_d = 8'(KBD_ROWS);
                        default: dout_d = dout_q;
                    endcase
                end
                CMD_KEY: begin
                    // Rows outside the matrix match no loop entry, so no write and no pulse
                    for (int r = 0; r < KBD_ROWS; r++) begin
                        for (int c = 0; c < 8; c++) begin
                            if ((data_in[3:0] == 4'(r)) && (data_in[6:4] == 3'(c))) begin
                                kbd_d[r*8+c] = data_in[7];
                                kbd_event_d  = 1'b1;
                            end
                        end
                    end
                end
                CMD_MOUSE: begin
                    case (idx_q)
                        4'd1:    btn_d = data_in[2:0];
                        4'd2:    add_x = 1'b1;
                        4'd3:    add_y = 1'b1;
                        default: btn_d = btn_q;
                    endcase
                end
                CMD_JOY: begin
                    if (idx_q == 4'd1) begin
                        dev_d = data_in;
                    end else if (idx_q == 4'd2) begin
                        for (int j = 0; j < JOY_COUNT; j++) begin
                            if (dev_q == 8'(j)) joy_d[j*8 +: 8] = data_in;
                        end
                    end
                end
                CMD_RATE: begin
                    if (idx_q == 4'd1) begin
                        rate_lo_d = data_in;
                    end else if (idx_q == 4'd2) begin
                        rate_full = {data_in[DIV_W-9:0], rate_lo_q};
                        reload_d  = (rate_full == '0) ? DIV_ONE : rate_full;
                    end
                end
                default: cmd_d = cmd_q;
            endcase
        end
    end

    // Free-running step divider; a new reload is picked up at the next tick
    always_comb begin
        tick  = (div_q == '0);
        div_d = tick ? reload_q : div_q - DIV_ONE;
    end

    // Parser, output and divider registers
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cmd_q       <= 8'h00;
            idx_q       <= 4'd0;
            dout_q      <= 8'h00;
            kbd_q       <= '1;
            joy_q       <= '0;
            dev_q       <= 8'h00;
            btn_q       <= 3'b000;
            kbd_event_q <= 1'b0;
            rate_lo_q   <= 8'h00;
            reload_q    <= DIV_INIT;
            div_q       <= DIV_INIT;
        end else begin
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            dout_q      <= dout_d;
            kbd_q       <= kbd_d;
            joy_q       <= joy_d;
            dev_q       <= dev_d;
            btn_q       <= btn_d;
            kbd_event_q <= kbd_event_d;
            rate_lo_q   <= rate_lo_d;
            reload_q    <= reload_d;
            div_q       <= div_d;
        end
    end

    hid_quad_axis #(.CNT_W(CNT_W)) u_axis_x (
        .clk    (clk),
        .rst_n  (rst_n_int),
        .add_en (add_x),
        .delta  (data_in),
        .tick   (tick),
        .q      (mouse_x)
    );

    hid_quad_axis #(.CNT_W(CNT_W)) u_axis_y (
        .clk    (clk),
        .rst_n  (rst_n_int),
        .add_en (add_y),
        .delta  (data_in),
        .tick   (tick),
        .q      (mouse_y)
    );

    assign data_out  = dout_q;
    assign keyboard  = kbd_q;
    assign joystick  = joy_q;
    assign mouse_btn = btn_q;
    assign kbd_event = kbd_event_q;

endmodule

// File: tb/tb_hid_mcu_if.sv
`timescale 1ns/1ps
module tb_hid_mcu_if;

    localparam int KR = 15;
    localparam int JC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        stb0, st0, stb1, st1;
    logic [7:0]  din0, din1;

    logic [7:0]      dout0, dout1;
    logic [KR*8-1:0] kbd0, kbd1;
    logic [JC*8-1:0] joy0, joy1;
    logic [2:0]      btn0, btn1;
    logic [1:0]      mx0, my0, mx1, my1;
    logic            evt0, evt1;

    hid_mcu_if u_dut (
        .clk(clk), .reset_n(reset_n), .data_in_strobe(stb0), .data_in_start(st0),
        .data_in(din0), .data_out(dout0), .keyboard(kbd0), .joystick(joy0),
        .mouse_btn(btn0), .mouse_x(mx0), .mouse_y(my0), .kbd_event(evt0)
    );

    hid_mcu_if #(.CNT_W(8), .DIV_RESET(300)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .data_in_strobe(stb1), .data_in_start(st1),
        .data_in(din1), .data_out(dout1), .keyboard(kbd1), .joystick(joy1),
        .mouse_btn(btn1), .mouse_x(mx1), .mouse_y(my1), .kbd_event(evt1)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every quadrature change with the cycle it was seen
    logic [1:0] px0, py0, px1;
    logic [1:0] xq0[$];
    int         xc0[$];
    logic [1:0] xq1[$];
    int         xc1[$];
    int         ny0 = 0;
    always @(negedge clk) begin
        if (mx0 !== px0) begin xq0.push_back(mx0); xc0.push_back(cyc); end
        if (mx1 !== px1) begin xq1.push_back(mx1); xc1.push_back(cyc); end
        if (my0 !== py0) ny0 <= ny0 + 1;
        px0 <= mx0;
        py0 <= my0;
        px1 <= mx1;
    end

    typedef struct {
        bit         st;
        logic [7:0] din;
        logic [7:0] dout;
        logic [7:0] r0;
        logic [7:0] r3;
        logic [7:0] r14;
        logic [15:0] joy;
        bit         evt;
    } vec_t;
    vec_t vq[$];

    task automatic add_vec(input bit st, input logic [7:0] din, input logic [7:0] dout,
                           input logic [7:0] r0, input logic [7:0] r3, input logic [7:0] r14,
                           input logic [15:0] joy, input bit evt);
        vec_t v;
        v.st = st; v.din = din; v.dout = dout; v.r0 = r0; v.r3 = r3; v.r14 = r14;
        v.joy = joy; v.evt = evt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit sel, input bit st, input logic [7:0] d);
        @(negedge clk);
        if (sel) begin stb1 = 1'b1; st1 = st; din1 = d; end
        else     begin stb0 = 1'b1; st0 = st; din0 = d; end
        @(negedge clk);
        stb0 = 1'b0; st0 = 1'b0; stb1 = 1'b0; st1 = 1'b0;
    endtask

    task automatic mouse_frame(input bit sel, input logic [7:0] b, input logic [7:0] dx, input logic [7:0] dy);
        send(sel, 1'b1, 8'h02);
        send(sel, 1'b0, b);
        send(sel, 1'b0, dx);
        send(sel, 1'b0, dy);
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] g);
        logic [1:0] seq [4];
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
        for (int i = 0; i < 4; i++) if (seq[i] == g) return seq[(i + 1) % 4];
        return 2'bxx;
    endfunction

    function automatic logic [1:0] q_at(input logic [1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 2'bxx;
    endfunction

    function automatic int c_at(input int c[$], input int i);
        return (i < c.size()) ? c[i] : -1000;
    endfunction

    initial begin
        int b, n;
        logic [1:0] g;
        logic [1:0] exp5 [5];
        reset_n = 1'b0;
        stb0 = 1'b0; st0 = 1'b0; din0 = 8'h00;
        stb1 = 1'b0; st1 = 1'b0; din1 = 8'h00;

        // Table: status, keyboard, joystick, abort, unknown command
        add_vec(1, 8'h00, 8'h00, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h11, 8'h5c, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h11, 8'h42, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h11, 8'h02, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h11, 8'h0f, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h11, 8'h0f, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(1, 8'h01, 8'h0f, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h23, 8'h0f, 8'hff, 8'hfb, 8'hff, 16'h0000, 1);
        add_vec(0, 8'hA3, 8'h0f, 8'hff, 8'hff, 8'hff, 16'h0000, 1);
        add_vec(0, 8'h0F, 8'h0f, 8'hff, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h40, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h0000, 1);
        add_vec(0, 8'h7E, 8'h0f, 8'hef, 8'hff, 8'h7f, 16'h0000, 1);
        add_vec(0, 8'hFE, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h0000, 1);
        add_vec(1, 8'h03, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h01, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h0000, 0);
        add_vec(0, 8'h5A, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h5a00, 0);
        add_vec(1, 8'h03, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'h05, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'h77, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h5a00, 0);
        add_vec(1, 8'h03, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'h00, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h5a00, 0);
        add_vec(1, 8'h01, 8'h0f, 8'hef, 8'hff, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'h13, 8'h0f, 8'hef, 8'hfd, 8'hff, 16'h5a00, 1);
        add_vec(1, 8'h09, 8'h0f, 8'hef, 8'hfd, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'h23, 8'h0f, 8'hef, 8'hfd, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'hA3, 8'h0f, 8'hef, 8'hfd, 8'hff, 16'h5a00, 0);
        add_vec(1, 8'h00, 8'h0f, 8'hef, 8'hfd, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'h00, 8'h5c, 8'hef, 8'hfd, 8'hff, 16'h5a00, 0);
        add_vec(0, 8'h00, 8'h42, 8'hef, 8'hfd, 8'hff, 16'h5a00, 0);

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_dout", dout0, 8'h00);
        check("rst_kbd_r0", kbd0[0 +: 8], 8'hff);
        check("rst_kbd_r14", kbd0[112 +: 8], 8'hff);
        check("rst_joy", joy0, 16'h0000);
        check("rst_btn", btn0, 3'b000);
        check("rst_mx", mx0, 2'b00);
        check("rst_my", my0, 2'b00);
        check("rst_evt", evt0, 1'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Byte while idle is ignored
        send(0, 1'b0, 8'h23);
        check("idle_r3", kbd0[24 +: 8], 8'hff);
        check("idle_evt", evt0, 1'b0);

        // Main DUT: rate reload 3, effective after its first divider expiry
        send(0, 1'b1, 8'h04);
        send(0, 1'b0, 8'h03);
        send(0, 1'b0, 8'h00);

        // Narrow-accumulator DUT: reload 1, then +127 twice saturates at 127
        b = xq1.size();
        send(1, 1'b1, 8'h04);
        send(1, 1'b0, 8'h01);
        send(1, 1'b0, 8'h00);
        mouse_frame(1, 8'h00, 8'h7f, 8'h00);
        mouse_frame(1, 8'h00, 8'h7f, 8'h00);
        while (cyc < 1000) @(negedge clk);
        n = xq1.size() - b;
        check("sat_steps", n, 127);
        check("sat_last_gray", q_at(xq1, xq1.size() - 1), 2'b10);
        check("sat_step_gap", c_at(xc1, xq1.size() - 1) - c_at(xc1, xq1.size() - 2), 2);

        // Table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            send(0, vq[i].st, vq[i].din);
            check($sformatf("v%0d_dout", i), dout0, vq[i].dout);
            check($sformatf("v%0d_r0", i), kbd0[0 +: 8], vq[i].r0);
            check($sformatf("v%0d_r3", i), kbd0[24 +: 8], vq[i].r3);
            check($sformatf("v%0d_r14", i), kbd0[112 +: 8], vq[i].r14);
            check($sformatf("v%0d_joy", i), joy0, vq[i].joy);
            check($sformatf("v%0d_evt", i), evt0, vq[i].evt);
        end

        // Long key frame: index saturates but every byte keeps acting
        send(0, 1'b1, 8'h01);
        for (int i = 0; i < 20; i++) begin
            send(0, 1'b0, (i % 2 == 1) ? 8'h80 : 8'h00);
            check($sformatf("long_key%0d", i), kbd0[0 +: 8], (i % 2 == 1) ? 8'hef : 8'hee);
        end

        // Mouse: wait until the reload of 3 is active on the main DUT
        while (cyc < 16700) @(negedge clk);
        b = xq0.size();
        n = ny0;
        mouse_frame(0, 8'h05, 8'h05, 8'h00);
        check("mouse_btn", btn0, 3'b101);
        repeat (40) @(negedge clk);
        exp5[0] = 2'b01; exp5[1] = 2'b11; exp5[2] = 2'b10; exp5[3] = 2'b00; exp5[4] = 2'b01;
        check("dx5_steps", xq0.size() - b, 5);
        for (int i = 0; i < 5; i++) check($sformatf("dx5_gray%0d", i), q_at(xq0, b + i), exp5[i]);
        for (int i = 1; i < 5; i++)
            check($sformatf("dx5_gap%0d", i), c_at(xc0, b + i) - c_at(xc0, b + i - 1), 4);
        check("dx5_no_y", ny0 - n, 0);

        b = xq0.size();
        mouse_frame(0, 8'h05, 8'hFE, 8'h00);
        repeat (30) @(negedge clk);
        check("dxm2_steps", xq0.size() - b, 2);
        check("dxm2_gray0", q_at(xq0, b), 2'b00);
        check("dxm2_gray1", q_at(xq0, b + 1), 2'b10);

        // Add landing on every divider phase: total steps equal sum of deltas
        g = 2'b10;
        for (int k = 0; k < 4; k++) begin
            b = xq0.size();
            mouse_frame(0, 8'h00, 8'h06, 8'h00);
            repeat (k) @(negedge clk);
            mouse_frame(0, 8'h00, 8'h02, 8'h00);
            repeat (60) @(negedge clk);
            check($sformatf("coin%0d_steps", k), xq0.size() - b, 8);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("coin%0d_gray%0d", k, i), q_at(xq0, b + i), fwd(g));
                g = fwd(g);
            end
        end

        // Reset in the middle of a frame with motion pending
        send(0, 1'b1, 8'h01);
        send(0, 1'b0, 8'h23);
        mouse_frame(0, 8'h07, 8'h32, 8'h00);
        send(0, 1'b1, 8'h03);
        send(0, 1'b0, 8'h01);
        repeat (3) @(negedge clk);
        check("pre_rst_btn", btn0, 3'b111);
        check("pre_rst_r3", kbd0[24 +: 8], 8'hf9);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_dout", dout0, 8'h00);
        check("arst_r3", kbd0[24 +: 8], 8'hff);
        check("arst_r0", kbd0[0 +: 8], 8'hff);
        check("arst_joy", joy0, 16'h0000);
        check("arst_btn", btn0, 3'b000);
        check("arst_mx", mx0, 2'b00);
        check("arst_evt", evt0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        b = xq0.size();
        send(0, 1'b0, 8'h5A);
        check("post_rst_joy", joy0, 16'h0000);
        check("post_rst_evt", evt0, 1'b0);
        repeat (30) @(negedge clk);
        check("post_rst_no_x", xq0.size() - b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
